// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX stage: ALU operation encoding and forwarding-source select.
package id_ex_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_LUI  = 4'd10
    } alu_operation_type;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EXM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

endpackage

// File: rtl/id_ex_stage_forward_mux.sv
// Per-operand bypass select: EX/MEM result beats MEM/WB result beats register-file data.
module id_ex_stage_forward_mux
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic [DATA_WIDTH-1:0] i_reg_data,
    input  logic                  i_exm_reg_write,
    input  logic [REG_ADDR_W-1:0] i_exm_rd,
    input  logic [DATA_WIDTH-1:0] i_exm_result,
    input  logic                  i_wb_reg_write,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    input  logic [DATA_WIDTH-1:0] i_wb_result,
    output logic [DATA_WIDTH-1:0] o_data,
    output fwd_sel_t              o_sel
);

    logic w_exm_hit;
    logic w_wb_hit;

    // x0 is hard-wired zero, so a write to it must never be bypassed
    assign w_exm_hit = i_exm_reg_write & (i_exm_rd != {REG_ADDR_W{1'b0}}) & (i_exm_rd == i_rs);
    assign w_wb_hit  = i_wb_reg_write  & (i_wb_rd  != {REG_ADDR_W{1'b0}}) & (i_wb_rd  == i_rs);

    // Priority select of the youngest producer
    always_comb begin
        o_data = i_reg_data;
        o_sel  = FWD_REG;
        if (w_exm_hit) begin
            o_data = i_exm_result;
            o_sel  = FWD_EXM;
        end else if (w_wb_hit) begin
            o_data = i_wb_result;
            o_sel  = FWD_WB;
        end else begin
            o_data = i_reg_data;
            o_sel  = FWD_REG;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, operand forwarding and load-use bubble.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_rs1_data,
    input  logic [DATA_WIDTH-1:0] in_rs2_data,
    input  logic [REG_ADDR_W-1:0] in_rs1,
    input  logic [REG_ADDR_W-1:0] in_rs2,
    input  logic                  in_rs1_used,
    input  logic                  in_rs2_used,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  alu_operation_type     in_op,
    input  logic                  in_src_pc,
    input  logic                  in_src_imm,
    input  logic                  in_reg_write,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    input  logic                  exm_reg_write,
    input  logic [REG_ADDR_W-1:0] exm_rd,
    input  logic [DATA_WIDTH-1:0] exm_result,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output alu_operation_type     alu_op,
    output logic [DATA_WIDTH-1:0] out_store_data,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  load_use_stall
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_rs1_data;
    logic [DATA_WIDTH-1:0] r_rs2_data;
    logic [REG_ADDR_W-1:0] r_rs1;
    logic [REG_ADDR_W-1:0] r_rs2;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [DATA_WIDTH-1:0] r_imm;
    alu_operation_type     r_op;
    logic                  r_src_pc;
    logic                  r_src_imm;
    logic                  r_reg_write;
    logic                  r_mem_read;
    logic                  r_mem_write;

    logic                  w_load_use;
    logic                  w_stall;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_rs1_fwd;
    logic [DATA_WIDTH-1:0] w_rs2_fwd;
    fwd_sel_t              w_rs1_sel;
    fwd_sel_t              w_rs2_sel;

    // A load in this stage cannot feed a dependent instruction in decode; it must wait one cycle
    assign w_load_use = r_valid & r_mem_read & (r_rd != {REG_ADDR_W{1'b0}}) & in_valid
                      & ((in_rs1_used & (in_rs1 == r_rd)) | (in_rs2_used & (in_rs2 == r_rd)));
    assign w_stall    = w_load_use & ~flush;
    assign in_ready   = (~r_valid | out_ready) & ~w_stall;
    assign w_accept   = in_valid & in_ready;

    // Pipeline register; a bubble only clears valid, control fields are left for out_valid to qualify
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_pc        <= {DATA_WIDTH{1'b0}};
            r_rs1_data  <= {DATA_WIDTH{1'b0}};
            r_rs2_data  <= {DATA_WIDTH{1'b0}};
            r_rs1       <= {REG_ADDR_W{1'b0}};
            r_rs2       <= {REG_ADDR_W{1'b0}};
            r_rd        <= {REG_ADDR_W{1'b0}};
            r_imm       <= {DATA_WIDTH{1'b0}};
            r_op        <= ALU_ADD;
            r_src_pc    <= 1'b0;
            r_src_imm   <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid     <= 1'b1;
            r_pc        <= in_pc;
            r_rs1_data  <= in_rs1_data;
            r_rs2_data  <= in_rs2_data;
            r_rs1       <= in_rs1;
            r_rs2       <= in_rs2;
            r_rd        <= in_rd;
            r_imm       <= in_imm;
            r_op        <= in_op;
            r_src_pc    <= in_src_pc;
            r_src_imm   <= in_src_imm;
            r_reg_write <= in_reg_write;
            r_mem_read  <= in_mem_read;
            r_mem_write <= in_mem_write;
        end else if (r_valid & out_ready) begin
            // covers both the load-use bubble and a plain drain
            r_valid <= 1'b0;
        end
    end

    id_ex_stage_forward_mux #(
        .DATA_WIDTH(DATA_WIDTH),
        .REG_ADDR_W(REG_ADDR_W)
    ) u_fwd_rs1 (
        .i_rs            (r_rs1),
        .i_reg_data      (r_rs1_data),
        .i_exm_reg_write (exm_reg_write),
        .i_exm_rd        (exm_rd),
        .i_exm_result    (exm_result),
        .i_wb_reg_write  (wb_reg_write),
        .i_wb_rd         (wb_rd),
        .i_wb_result     (wb_result),
        .o_data          (w_rs1_fwd),
        .o_sel           (w_rs1_sel)
    );

    id_ex_stage_forward_mux #(
        .DATA_WIDTH(DATA_WIDTH),
        .REG_ADDR_W(REG_ADDR_W)
    ) u_fwd_rs2 (
        .i_rs            (r_rs2),
        .i_reg_data      (r_rs2_data),
        .i_exm_reg_write (exm_reg_write),
        .i_exm_rd        (exm_rd),
        .i_exm_result    (exm_result),
        .i_wb_reg_write  (wb_reg_write),
        .i_wb_rd         (wb_rd),
        .i_wb_result     (wb_result),
        .o_data          (w_rs2_fwd),
        .o_sel           (w_rs2_sel)
    );

    assign alu_a          = r_src_pc  ? r_pc  : w_rs1_fwd;
    assign alu_b          = r_src_imm ? r_imm : w_rs2_fwd;
    assign alu_op         = r_op;
    assign out_store_data = w_rs2_fwd;
    assign out_valid      = r_valid;
    assign out_rd         = r_rd;
    assign out_pc         = r_pc;
    assign out_reg_write  = r_reg_write;
    assign out_mem_read   = r_mem_read;
    assign out_mem_write  = r_mem_write;
    assign load_use_stall = w_stall;

endmodule
